// File: rtl/button_event_capture_pkg.sv
// Shared constants for the button/interrupt front end of the rhythm-game CPU.
// Holds the default channel count, debounce window and timestamp width.
package button_event_capture_pkg;

    localparam int unsigned NUM_BTN         = 20;
    localparam int unsigned DEBOUNCE_CYCLES = 50000;
    localparam int unsigned CNT_W           = 16;
    localparam int unsigned WIDTH           = 32;

    // At a 50 MHz clock the default debounce window is exactly one millisecond tick.
    localparam int unsigned CLK_HZ          = 50_000_000;
    localparam int unsigned TICKS_PER_MS    = CLK_HZ / 1000;

endpackage

// File: rtl/button_event_capture_if.sv
// Bundle between the board/CPU side (master) and the capture block (slave).
interface button_event_capture_if
    import button_event_capture_pkg::*;
#(
    parameter int unsigned NUM_BTN = button_event_capture_pkg::NUM_BTN,
    parameter int unsigned WIDTH   = button_event_capture_pkg::WIDTH
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [WIDTH-1:0]   millis;
    logic [NUM_BTN-1:0] ack;
    logic [NUM_BTN-1:0] interrupt;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] overrun;
    logic [WIDTH-1:0]   last_ts;
    logic               any_pend;

    modport master (
        output btn_raw, millis, ack,
        input  interrupt, btn_level, overrun, last_ts, any_pend
    );

    modport slave (
        input  btn_raw, millis, ack,
        output interrupt, btn_level, overrun, last_ts, any_pend
    );
endinterface

// File: rtl/button_event_capture_debounce.sv
// One button channel: 2-flop synchroniser, hold counter and accepted stable level.
module btn_debounce_bit
    import button_event_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = button_event_capture_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = button_event_capture_pkg::CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);
    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = r_s2 ^ r_stable;
    assign w_accept = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_stable;
    // High during the cycle whose closing edge flips stable 0->1, so the
    // pending flag and the level update on the same edge.
    assign o_rise  = w_accept & r_s2;
endmodule

// File: rtl/button_event_capture.sv
// Debounced press capture feeding the CPU interrupt bus, with sticky
// pending/overrun flags and a millisecond timestamp of the latest press.
module button_event_capture
    import button_event_capture_pkg::*;
#(
    parameter int unsigned NUM_BTN         = button_event_capture_pkg::NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = button_event_capture_pkg::DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = button_event_capture_pkg::CNT_W,
    parameter int unsigned WIDTH           = button_event_capture_pkg::WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    button_event_capture_if.slave  bus
);
    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] r_int;
    logic [NUM_BTN-1:0] r_ovr;
    logic [WIDTH-1:0]   r_ts;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_raw   (bus.btn_raw[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    // A press always sets pending even against a same-edge ack; an ack in
    // that cycle means the CPU consumed the old event, so it is not an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int <= '0;
            r_ovr <= '0;
            r_ts  <= '0;
        end else begin
            r_int <= w_rise | (r_int & ~bus.ack);
            r_ovr <= ~bus.ack & (r_ovr | (w_rise & r_int));
            if (|w_rise)
                r_ts <= bus.millis;
        end
    end

    assign bus.interrupt = r_int;
    assign bus.btn_level = w_level;
    assign bus.overrun   = r_ovr;
    assign bus.last_ts   = r_ts;
    assign bus.any_pend  = |r_int;
endmodule

// File: tb/tb_button_event_capture.sv
// Directed bench for button_event_capture with a 4-cycle debounce window.
module tb_button_event_capture;
    localparam int NB = 20;
    localparam int TW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    button_event_capture_if #(.NUM_BTN(NB), .WIDTH(TW)) bus ();

    button_event_capture #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .CNT_W(3), .WIDTH(TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] ack;
        logic [TW-1:0] ms;
        logic [NB-1:0] e_int;
        logic [NB-1:0] e_lvl;
        logic [NB-1:0] e_ovr;
        logic [TW-1:0] e_ts;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [NB-1:0] raw, logic [NB-1:0] ack, logic [TW-1:0] ms,
                                logic [NB-1:0] ei, logic [NB-1:0] el, logic [NB-1:0] eo,
                                logic [TW-1:0] ets);
        vec_t v;
        v.raw = raw; v.ack = ack; v.ms = ms;
        v.e_int = ei; v.e_lvl = el; v.e_ovr = eo; v.e_ts = ets;
        tbl.push_back(v);
    endfunction

    // Six edges with raw held: five with the old expectation, the sixth with the new one.
    function automatic void settle(logic [NB-1:0] raw, logic [TW-1:0] ms0,
                                   logic [NB-1:0] ei0, logic [NB-1:0] el0, logic [TW-1:0] ts0,
                                   logic [NB-1:0] ei1, logic [NB-1:0] el1, logic [TW-1:0] ts1);
        for (int k = 0; k < 5; k++) add(raw, '0, ms0 + TW'(k), ei0, el0, '0, ts0);
        add(raw, '0, ms0 + TW'(5), ei1, el1, '0, ts1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic [NB-1:0] ei, input logic [NB-1:0] el,
                           input logic [NB-1:0] eo, input logic [TW-1:0] ets);
        chk({tag, " interrupt"}, 32'(bus.interrupt), 32'(ei));
        chk({tag, " btn_level"}, 32'(bus.btn_level), 32'(el));
        chk({tag, " overrun"},   32'(bus.overrun),   32'(eo));
        chk({tag, " last_ts"},   bus.last_ts,        ets);
        chk({tag, " any_pend"},  32'(bus.any_pend),  32'(|ei));
    endtask

    initial begin
        bus.btn_raw = '0;
        bus.ack     = '0;
        bus.millis  = '0;

        tick(2);
        chk_all("reset", '0, '0, '0, '0);
        rst = 1'b0;

        // Clean press on bit 3, then ack
        settle(20'h00008, 32'h10, '0, '0, '0, 20'h00008, 20'h00008, 32'h15);
        add(20'h00008, 20'h00008, 32'h16, '0, 20'h00008, '0, 32'h15);
        // Glitch on bit 0 must leave everything alone
        for (int k = 0; k < 3; k++) add(20'h00009, '0, 32'h20 + k, '0, 20'h00008, '0, 32'h15);
        for (int k = 0; k < 5; k++) add(20'h00008, '0, 32'h23 + k, '0, 20'h00008, '0, 32'h15);
        // Release of bit 3 drops the level but raises no event
        settle(20'h00000, 32'h30, '0, 20'h00008, 32'h15, '0, '0, 32'h15);
        // Bits 1 and 19 together share the timestamp 0x1F4
        settle(20'h80002, 32'h1EF, '0, '0, 32'h15, 20'h80002, 20'h80002, 32'h1F4);
        add(20'h80002, 20'h80002, 32'h1F5, '0, 20'h80002, '0, 32'h1F4);
        settle(20'h00000, 32'h200, '0, 20'h80002, 32'h1F4, '0, '0, 32'h1F4);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.btn_raw = tbl[i].raw;
            bus.ack     = tbl[i].ack;
            bus.millis  = tbl[i].ms;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_int, tbl[i].e_lvl, tbl[i].e_ovr, tbl[i].e_ts);
        end
        bus.ack = '0;

        // Collision: ack[5] on the same edge as the bit-5 press event
        bus.btn_raw = 20'h00020;
        bus.millis  = 32'h300;
        tick(5);
        chk("coll pre", 32'(bus.interrupt), 32'h0);
        bus.ack    = 20'h00020;
        bus.millis = 32'h305;
        tick();
        chk("coll set", 32'(bus.interrupt), 32'h00020);
        chk("coll ovr", 32'(bus.overrun), 32'h0);
        chk("coll ts", bus.last_ts, 32'h305);
        tick();
        chk("coll ack", 32'(bus.interrupt), 32'h0);
        bus.ack     = '0;
        bus.btn_raw = '0;
        tick(6);
        chk("coll rel", 32'(bus.btn_level), 32'h0);

        // Overrun: two presses on bit 7 without an ack
        bus.btn_raw = 20'h00080;
        tick(6);
        chk("ovr p1 int", 32'(bus.interrupt), 32'h00080);
        chk("ovr p1 ovr", 32'(bus.overrun), 32'h0);
        bus.btn_raw = '0;
        tick(6);
        chk("ovr rel lvl", 32'(bus.btn_level), 32'h0);
        chk("ovr rel int", 32'(bus.interrupt), 32'h00080);
        bus.btn_raw = 20'h00080;
        tick(6);
        chk("ovr p2 int", 32'(bus.interrupt), 32'h00080);
        chk("ovr p2 ovr", 32'(bus.overrun), 32'h00080);
        bus.ack = 20'h00080;
        tick();
        bus.ack = '0;
        chk("ovr ack int", 32'(bus.interrupt), 32'h0);
        chk("ovr ack ovr", 32'(bus.overrun), 32'h0);
        chk("ovr ack pend", 32'(bus.any_pend), 32'h0);

        // Reset at count 2 of a bit-9 press; bit 7 still held high
        bus.btn_raw = 20'h00280;
        bus.millis  = 32'h400;
        tick(4);
        chk("rst pre lvl", 32'(bus.btn_level), 32'h00080);
        chk("rst pre int", 32'(bus.interrupt), 32'h0);
        rst = 1'b1;
        #1;
        chk_all("rst async", '0, '0, '0, '0);
        tick(2);
        chk_all("rst held", '0, '0, '0, '0);
        rst = 1'b0;
        tick(5);
        chk("rst edge5 int", 32'(bus.interrupt), 32'h0);
        bus.millis = 32'h405;
        tick();
        chk_all("rst edge6", 20'h00280, 20'h00280, '0, 32'h405);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
